// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the processor data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DMEM_ADDR_WIDTH = 8;
  localparam int DMEM_DATA_WIDTH = 8;
  localparam int DMEM_LATENCY    = 5;

endpackage

// File: rtl/dmem_array.sv
// Byte storage: synchronous write, asynchronous read; contents are never reset.
// No handshake; the caller owns all sequencing.
module dmem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// Data memory with a programmable access latency; stalls the CPU through BUSYWAIT.
// DMEM_CONFLICT_ERR_EN turns simultaneous READ&WRITE into an ERROR pulse instead of a write.
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int LATENCY    = DMEM_LATENCY
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [DATA_WIDTH-1:0] READDATA,
  output logic                  BUSYWAIT
`ifdef DMEM_CONFLICT_ERR_EN
  ,
  output logic                  ERROR
`endif
);

  localparam int CW = $clog2(LATENCY + 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  op_wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  arr_we;
  logic                  err_q;

  // The array is touched only on the final BUSY edge, using the captured request.
  assign arr_we = (state == BUSY) && (cnt == '0) && op_wr;

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .CLK  (CLK),
    .we   (arr_we),
    .addr (addr_q),
    .wdata(data_q),
    .rdata(rd_dat)
  );

  assign BUSYWAIT = RESET && (((state == IDLE) && (READ || WRITE)) || (state == BUSY));

`ifdef DMEM_CONFLICT_ERR_EN
  assign ERROR = err_q;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      READDATA <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (READ || WRITE) begin
            addr_q <= ADDRESS;
            data_q <= WRITEDATA;
            op_wr  <= WRITE;
`ifdef DMEM_CONFLICT_ERR_EN
            if (READ && WRITE) begin
              state <= DONE;
              err_q <= 1'b1;
            end else begin
              cnt   <= CW'(LATENCY - 1);
              state <= BUSY;
            end
`else
            cnt   <= CW'(LATENCY - 1);
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            if (!op_wr) READDATA <= rd_dat;
            state <= DONE;
          end
        end
        DONE: begin
          // Request levels here belong to the instruction that just completed.
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a LATENCY=5 instance for the main checks, a LATENCY=1 instance for the minimum-latency case.
module tb_data_memory;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       READ, WRITE;
  logic [7:0] ADDRESS, WRITEDATA;
  logic [7:0] rd0, rd1;
  logic       bw0, bw1;
  logic       sel;
`ifdef DMEM_CONFLICT_ERR_EN
  logic       err0, err1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(5)) dut0 (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(rd0), .BUSYWAIT(bw0)
`ifdef DMEM_CONFLICT_ERR_EN
    , .ERROR(err0)
`endif
  );

  data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(rd1), .BUSYWAIT(bw1)
`ifdef DMEM_CONFLICT_ERR_EN
    , .ERROR(err1)
`endif
  );

  logic       bw_s;
  logic [7:0] rd_s;
  assign bw_s = sel ? bw1 : bw0;
  assign rd_s = sel ? rd1 : rd0;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a request at a falling edge; sampling starts 1 time unit later.
  task automatic start(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    #1;
  endtask

  // Count stall cycles until the DONE cycle; leaves time parked inside DONE.
  task automatic wait_done(output int nbusy);
    nbusy = 0;
    while (bw_s && nbusy < 50) begin
      nbusy++;
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic release_req();
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    int nb;
    logic [7:0] prev;

    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 6};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 6};
    vecs[2] = '{1'b0, 1'b1, 8'h11, 8'h5A, 8'hA5, 6};
    vecs[3] = '{1'b0, 1'b1, 8'h20, 8'h11, 8'hA5, 6};
    vecs[4] = '{1'b0, 1'b1, 8'h30, 8'h01, 8'hA5, 6};
    vecs[5] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h11, 6};
    vecs[6] = '{1'b0, 1'b1, 8'h40, 8'hEE, 8'h11, 6};

    sel = 1'b0;
    READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    RESET = 1'b1;
    #1 RESET = 1'b0;
    #2;
    check("reset_busywait", bw0, 1'b0);
    check("reset_readdata", rd0, 8'h00);
`ifdef DMEM_CONFLICT_ERR_EN
    check("reset_error", err0, 1'b0);
`endif
    READ = 1'b1;
    #1;
    check("reset_forces_busywait_low", bw0, 1'b0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_done(nb);
      check($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].exp_busy);
      check($sformatf("vec%0d_readdata", i), rd_s, vecs[i].exp_rd);
`ifdef DMEM_CONFLICT_ERR_EN
      check($sformatf("vec%0d_error", i), err0, 1'b0);
`endif
      release_req();
    end

    // READ held across two loads: the DONE cycle separates the accesses.
    start(1'b1, 1'b0, 8'h10, 8'h00);
    wait_done(nb);
    check("held_rd1_busy", nb, 6);
    check("held_rd1_data", rd0, 8'hA5);
    ADDRESS = 8'h11;
    #1;
    check("held_done_busywait", bw0, 1'b0);
    @(negedge CLK); #1;
    check("held_rd2_request_stall", bw0, 1'b1);
    wait_done(nb);
    check("held_rd2_busy", nb, 6);
    check("held_rd2_data", rd0, 8'h5A);
    release_req();

    // Reset two cycles into a write's BUSY phase.
    start(1'b0, 1'b1, 8'h20, 8'h3C);
    @(negedge CLK);
    @(negedge CLK);
    check("pre_abort_busywait", bw0, 1'b1);
    RESET = 1'b0;
    #1;
    check("abort_busywait", bw0, 1'b0);
    check("abort_readdata", rd0, 8'h00);
    release_req();
    @(negedge CLK);
    RESET = 1'b1;
    start(1'b1, 1'b0, 8'h20, 8'h00);
    wait_done(nb);
    check("abort_write_discarded", rd0, 8'h11);
    release_req();

    // Address and data change mid-BUSY must not affect the captured read.
    start(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge CLK);
    ADDRESS = 8'h40; WRITEDATA = 8'h99;
    #1;
    wait_done(nb);
    check("addr_change_busy", nb, 5);
    check("addr_change_data", rd0, 8'hA5);
    release_req();

    // Simultaneous READ and WRITE.
    prev = rd0;
    start(1'b1, 1'b1, 8'h30, 8'h77);
    wait_done(nb);
`ifdef DMEM_CONFLICT_ERR_EN
    check("conflict_busy", nb, 1);
    check("conflict_error_pulse", err0, 1'b1);
    release_req();
    @(negedge CLK); #1;
    check("conflict_error_cleared", err0, 1'b0);
    check("conflict_readdata_kept", rd0, prev);
    start(1'b1, 1'b0, 8'h30, 8'h00);
    wait_done(nb);
    check("conflict_no_write", rd0, 8'h01);
`else
    check("conflict_busy", nb, 6);
    check("conflict_readdata_kept", rd0, prev);
    release_req();
    start(1'b1, 1'b0, 8'h30, 8'h00);
    wait_done(nb);
    check("conflict_as_write", rd0, 8'h77);
`endif
    release_req();

    // Minimum latency on the top address.
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    sel = 1'b1;
    start(1'b0, 1'b1, 8'h00, 8'h00);
    wait_done(nb);
    release_req();
    start(1'b0, 1'b1, 8'hFF, 8'hFF);
    wait_done(nb);
    check("lat1_write_busy", nb, 2);
    release_req();
    start(1'b1, 1'b0, 8'hFF, 8'h00);
    wait_done(nb);
    check("lat1_read_busy", nb, 2);
    check("lat1_read_data", rd1, 8'hFF);
    release_req();
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
